// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Radix-2 shift-add multiply and restoring divide on magnitudes, followed by a sign-fix cycle.
module muldiv_unit #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_NONE = 3'b000, OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
    OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110, OP_NONE7 = 3'b111
  } op_t;

  localparam int unsigned CW = $clog2(ITER);
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  state_t        r_state, r_next;
  logic [CW-1:0] r_cnt;
  logic [63:0]   r_p;
  logic [31:0]   r_b;
  logic          r_is_div, r_neg_lo, r_neg_hi, r_dbz;
  logic [31:0]   r_hi, r_lo;

  logic        w_accept, w_is_mul, w_is_div, w_signed, w_rs_neg, w_rt_neg;
  logic [31:0] w_mag_a, w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [31:0] w_div_rem;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  always_comb begin
    w_accept = clk_enable && start && (r_state == S_IDLE);
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_rs_neg = w_signed && rs[31];
    w_rt_neg = w_signed && rt[31];
    w_mag_a  = w_rs_neg ? (~rs + 32'd1) : rs;
    w_mag_b  = w_rt_neg ? (~rt + 32'd1) : rt;
  end

  // Multiply: r_p = {partial product, remaining multiplier bits}; r_b = multiplicand.
  always_comb begin
    w_mul_sum  = {1'b0, r_p[63:32]} + (r_p[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_mul_sum, r_p[31:1]};
  end

  // Divide: r_p = {partial remainder, dividend shifting into quotient}; r_b = divisor.
  always_comb begin
    w_div_shift = {r_p[63:32], r_p[31]};
    w_div_ge    = w_div_shift >= {1'b0, r_b};
    w_div_rem   = w_div_shift[31:0] - r_b;
    w_div_next  = w_div_ge ? {w_div_rem, r_p[30:0], 1'b1}
                           : {w_div_shift[31:0], r_p[30:0], 1'b0};
  end

  always_comb begin
    w_prod = r_neg_lo ? (~r_p + 64'd1) : r_p;
    w_quo  = r_neg_lo ? (~r_p[31:0] + 32'd1) : r_p[31:0];
    w_rem  = r_neg_hi ? (~r_p[63:32] + 32'd1) : r_p[63:32];
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && (w_is_mul || w_is_div)) r_next = S_RUN;
      S_RUN:  if (clk_enable && (r_cnt == LAST)) r_next = S_FIX;
      S_FIX:  if (clk_enable) r_next = S_IDLE;
      default: r_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= r_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_lo <= 1'b0;
      r_neg_hi <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (clk_enable) begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MTHI) r_hi <= rs;
            if (op == OP_MTLO) r_lo <= rs;
            if (w_is_mul || w_is_div) begin
              r_cnt    <= '0;
              r_is_div <= w_is_div;
              r_neg_lo <= w_rs_neg ^ w_rt_neg;
              r_neg_hi <= w_rs_neg;
              r_dbz    <= w_is_div && (rt == '0);
              r_p      <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
              r_b      <= w_is_div ? w_mag_b : w_mag_a;
            end
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          r_p   <= r_is_div ? w_div_next : w_mul_next;
        end
        S_FIX: begin
          if (!r_is_div) begin
            r_hi <= w_prod[63:32];
            r_lo <= w_prod[31:0];
          end else if (!r_dbz) begin
            r_hi <= w_rem;
            r_lo <= w_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO/busy-length, a monitor pops on busy fall.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, clk_enable, start;
  logic [2:0]  op;
  logic [31:0] rs, rt;
  logic        busy;
  logic [31:0] hi, lo;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;   // 0: busy length not checked
  } exp_t;

  exp_t sb[$];

  muldiv_unit #(.ITER(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .op(op), .rs(rs), .rt(rt), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input string nm, input logic [31:0] h, input logic [31:0] l,
                      input int unsigned len);
    exp_t e;
    e.name = nm; e.hi = h; e.lo = l; e.len = len;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    start = 1'b1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 1'b0; op = 3'b000; rs = 32'hCAFEF00D; rt = 32'h13579BDF;
  endtask

  task automatic wait_idle(input string nm);
    int unsigned k;
    k = 0;
    while (busy === 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy === 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: busy still %b, expected 0 within 200 cycles", nm, busy);
    end
  endtask

  // Monitor: counts busy cycles and checks HI/LO when busy drops.
  initial begin
    int unsigned blen;
    logic        pbusy;
    exp_t        e;
    blen  = 0;
    pbusy = 1'b0;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen++;
      end else begin
        if (pbusy === 1'b1) begin
          if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_completion: got busy fall, expected none");
          end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            if (e.len != 0) check({e.name, "_busylen"}, 32'(blen), 32'(e.len));
          end
        end
        blen = 0;
      end
      pbusy = busy;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; clk_enable = 1'b1; start = 1'b0; op = 3'b000; rs = '0; rt = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);

    push("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 33);
    issue(3'b001, 32'hFFFFFFFD, 32'd5);
    wait_idle("mult_m3x5");

    push("multu_max", 32'hFFFFFFFE, 32'h00000001, 33);
    issue(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("multu_max");

    push("mult_m1xm1", 32'h00000000, 32'h00000001, 33);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle("mult_m1xm1");

    push("div_m7d2", 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    issue(3'b011, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_m7d2");

    push("divu_100d7", 32'd2, 32'd14, 33);
    issue(3'b100, 32'd100, 32'd7);
    wait_idle("divu_100d7");

    push("div_ovf", 32'h00000000, 32'h80000000, 33);
    issue(3'b011, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    issue(3'b101, 32'h12345678, 32'd0);
    issue(3'b110, 32'h9ABCDEF0, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mtlo_lo", lo, 32'h9ABCDEF0);
    check("mtxx_busy", {31'd0, busy}, 32'd0);

    push("divu_by0", 32'h12345678, 32'h9ABCDEF0, 33);
    issue(3'b100, 32'd55, 32'd0);
    wait_idle("divu_by0");

    // DIVU 1000/3 with an MTHI attempt and operand change mid-run.
    push("divu_busy_start", 32'd1, 32'd333, 33);
    issue(3'b100, 32'd1000, 32'd3);
    repeat (9) @(posedge clk);
    #1 start = 1'b1; op = 3'b101; rs = 32'hDEADBEEF; rt = 32'd1;
    @(posedge clk);
    #1 start = 1'b0; op = 3'b000;
    check("busy_start_hi_hold", hi, 32'h12345678);
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    wait_idle("divu_busy_start");

    // MULT 7 * -6 with clk_enable low for 5 cycles mid-run.
    push("mult_stall", 32'hFFFFFFFF, 32'hFFFFFFD6, 38);
    issue(3'b001, 32'd7, 32'hFFFFFFFA);
    repeat (8) @(posedge clk);
    #1 clk_enable = 1'b0;
    repeat (5) @(posedge clk);
    #1 clk_enable = 1'b1;
    wait_idle("mult_stall");

    // Reset at RUN cycle 10 aborts the MULTU; HI/LO clear and stay clear.
    push("reset_abort", 32'h0, 32'h0, 0);
    issue(3'b010, 32'd3, 32'd4);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("abort_hi_late", hi, 32'h0);
    check("abort_lo_late", lo, 32'h0);
    check("abort_busy_late", {31'd0, busy}, 32'd0);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
